// File: rtl/toggle_seq_pkg.sv
// Shared types and constants for the toggle-rate sequencer: FSM states,
// profile mode codes, the rate ceiling and the triangle direction flag.
package toggle_seq_pkg;

   localparam int MAX_RATE = 100;

   localparam logic [1:0] MODE_UP    = 2'd0;
   localparam logic [1:0] MODE_DOWN  = 2'd1;
   localparam logic [1:0] MODE_TRI   = 2'd2;
   localparam logic [1:0] MODE_FIXED = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } tri_dir_t;

endpackage

// File: rtl/toggle_dwell_timer.sv
// Loadable down-counter timing how long each rate level is held; expire
// pulses on the last cycle of the dwell while the sequencer is running.
module toggle_dwell_timer #(
   parameter int DWELL_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load,
   input  logic [DWELL_WIDTH-1:0] value,
   input  logic                   run,
   output logic                   expire
);

   logic [DWELL_WIDTH-1:0] cnt_q;

   // Loaded with value-1 so a dwell of N expires on its Nth cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= value - DWELL_WIDTH'(1);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - DWELL_WIDTH'(1);
      end
   end

   assign expire = run && (cnt_q == '0);

endmodule

// File: rtl/toggle_rate_sequencer.sv
// Profile sequencer producing toggle_rate for the power-load arrays.
// Optional macro TOGGLE_SEQ_CYCLE_COUNT_EN enables the run_cycles counter.
module toggle_rate_sequencer
   import toggle_seq_pkg::*;
#(
   parameter int TR_WIDTH    = 7,
   parameter int MAX_RATE    = toggle_seq_pkg::MAX_RATE,
   parameter int DWELL_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   stop,
   input  logic [1:0]             cfg_mode,
   input  logic [TR_WIDTH-1:0]    cfg_min,
   input  logic [TR_WIDTH-1:0]    cfg_max,
   input  logic [TR_WIDTH-1:0]    cfg_step,
   input  logic [DWELL_WIDTH-1:0] cfg_dwell,
   output logic [TR_WIDTH-1:0]    toggle_rate,
   output logic                   busy,
   output logic                   done,
   output logic                   step_strobe,
   output logic [31:0]            run_cycles
);

   localparam int AW = TR_WIDTH + 1;
   typedef logic [TR_WIDTH-1:0] rate_t;

   function automatic rate_t clamp_rate(input rate_t v);
      if (int'(v) > MAX_RATE) return rate_t'(MAX_RATE);
      return v;
   endfunction

   function automatic rate_t sat_add(input rate_t cur, input rate_t step, input rate_t lim);
      logic [AW-1:0] sum;
      sum = {1'b0, cur} + {1'b0, step};
      if (sum > {1'b0, lim}) return lim;
      return sum[TR_WIDTH-1:0];
   endfunction

   function automatic rate_t sat_sub(input rate_t cur, input rate_t step, input rate_t lim);
      logic signed [AW-1:0] diff;
      diff = $signed({1'b0, cur}) - $signed({1'b0, step});
      if (diff < $signed({1'b0, lim})) return lim;
      return diff[TR_WIDTH-1:0];
   endfunction

   seq_state_t state_q, state_d;
   tri_dir_t   dir_q, dir_d;
   rate_t      rate_q, rate_d;
   logic       busy_q, busy_d, strobe_q, strobe_d, done_q, done_d;

   rate_t                  s_min, s_max, s_step;
   logic [DWELL_WIDTH-1:0] s_dwell;
   logic [1:0]             sh_mode;
   rate_t                  sh_min, sh_max, sh_step;
   logic [DWELL_WIDTH-1:0] sh_dwell;

   logic                   start_fire, tmr_load, tmr_expire;
   logic [DWELL_WIDTH-1:0] tmr_value;

   // Sanitised view of the live configuration, captured at start.
   always_comb begin
      s_min   = clamp_rate(cfg_min);
      s_max   = clamp_rate(cfg_max);
      if (s_min > s_max) s_max = s_min;
      s_step  = (cfg_step == '0) ? rate_t'(1) : cfg_step;
      s_dwell = (cfg_dwell == '0) ? DWELL_WIDTH'(1) : cfg_dwell;
   end

   assign start_fire = (state_q == IDLE) && start && !stop;

   always_ff @(posedge clk) begin
      if (start_fire) begin
         sh_mode  <= cfg_mode;
         sh_min   <= s_min;
         sh_max   <= s_max;
         sh_step  <= s_step;
         sh_dwell <= s_dwell;
      end
   end

   toggle_dwell_timer #(.DWELL_WIDTH(DWELL_WIDTH)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (tmr_load),
      .value  (tmr_value),
      .run    (state_q == RUN),
      .expire (tmr_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         dir_q    <= DIR_UP;
         rate_q   <= '0;
         busy_q   <= 1'b0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_q    <= dir_d;
         rate_q   <= rate_d;
         busy_q   <= busy_d;
         strobe_q <= strobe_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      rate_d    = rate_q;
      busy_d    = busy_q;
      strobe_d  = 1'b0;
      done_d    = 1'b0;
      tmr_load  = 1'b0;
      tmr_value = sh_dwell;
      case (state_q)
         IDLE: begin
            rate_d = '0;
            busy_d = 1'b0;
            if (start_fire) begin
               state_d   = RUN;
               busy_d    = 1'b1;
               strobe_d  = 1'b1;
               dir_d     = DIR_UP;
               tmr_load  = 1'b1;
               tmr_value = s_dwell;
               rate_d    = (cfg_mode == MODE_DOWN) ? s_max : s_min;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               rate_d  = '0;
               busy_d  = 1'b0;
            end else if (tmr_expire) begin
               tmr_load = 1'b1;
               case (sh_mode)
                  MODE_UP: begin
                     if (rate_q == sh_max) begin
                        state_d  = DONE;
                        rate_d   = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        tmr_load = 1'b0;
                     end else begin
                        rate_d   = sat_add(rate_q, sh_step, sh_max);
                        strobe_d = 1'b1;
                     end
                  end
                  MODE_DOWN: begin
                     if (rate_q == sh_min) begin
                        state_d  = DONE;
                        rate_d   = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        tmr_load = 1'b0;
                     end else begin
                        rate_d   = sat_sub(rate_q, sh_step, sh_min);
                        strobe_d = 1'b1;
                     end
                  end
                  MODE_TRI: begin
                     strobe_d = 1'b1;
                     // Reverse on reaching an endpoint so it is held for a single dwell.
                     if (sh_min == sh_max) begin
                        rate_d = rate_q;
                     end else if (dir_q == DIR_UP) begin
                        if (rate_q == sh_max) begin
                           dir_d  = DIR_DOWN;
                           rate_d = sat_sub(rate_q, sh_step, sh_min);
                        end else begin
                           rate_d = sat_add(rate_q, sh_step, sh_max);
                        end
                     end else begin
                        if (rate_q == sh_min) begin
                           dir_d  = DIR_UP;
                           rate_d = sat_add(rate_q, sh_step, sh_max);
                        end else begin
                           rate_d = sat_sub(rate_q, sh_step, sh_min);
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
         DONE: begin
            state_d = IDLE;
            rate_d  = '0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            rate_d  = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign toggle_rate = rate_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign step_strobe = strobe_q;

`ifdef TOGGLE_SEQ_CYCLE_COUNT_EN
   logic [31:0] run_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt_q <= '0;
      end else if (start_fire) begin
         run_cnt_q <= '0;
      end else if (busy_q && (run_cnt_q != '1)) begin
         run_cnt_q <= run_cnt_q + 32'd1;
      end
   end

   assign run_cycles = run_cnt_q;
`else
   assign run_cycles = '0;
`endif

endmodule

// File: tb/tb_toggle_rate_sequencer.sv
// Directed self-checking bench for toggle_rate_sequencer.
module tb_toggle_rate_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stop;
   logic [1:0]  cfg_mode;
   logic [6:0]  cfg_min, cfg_max, cfg_step;
   logic [31:0] cfg_dwell;
   logic [6:0]  toggle_rate;
   logic        busy, done, step_strobe;
   logic [31:0] run_cycles;

   int n_chk = 0;
   int n_bad = 0;
   int exp_q[$];

   toggle_rate_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .cfg_mode    (cfg_mode),
      .cfg_min     (cfg_min),
      .cfg_max     (cfg_max),
      .cfg_step    (cfg_step),
      .cfg_dwell   (cfg_dwell),
      .toggle_rate (toggle_rate),
      .busy        (busy),
      .done        (done),
      .step_strobe (step_strobe),
      .run_cycles  (run_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run(input logic [1:0] m, input int mn, input int mx,
                            input int st, input int dw);
      cfg_mode  = m;
      cfg_min   = 7'(mn);
      cfg_max   = 7'(mx);
      cfg_step  = 7'(st);
      cfg_dwell = 32'(dw);
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   // Walks exp_q, each level held for dwell cycles; optionally expects completion.
   task automatic expect_seq(input int dwell, input bit exp_done);
      foreach (exp_q[i]) begin
         for (int c = 0; c < dwell; c++) begin
            chk("rate", 32'(toggle_rate), 32'(exp_q[i]));
            chk("strobe", 32'(step_strobe), (c == 0) ? 32'd1 : 32'd0);
            chk("busy", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
            tick();
         end
      end
      if (exp_done) begin
         chk("done", 32'(done), 32'd1);
         chk("done_rate", 32'(toggle_rate), 32'd0);
         chk("done_busy", 32'(busy), 32'd0);
         tick();
         chk("done_pulse", 32'(done), 32'd0);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      stop      = 1'b0;
      cfg_mode  = 2'd0;
      cfg_min   = '0;
      cfg_max   = '0;
      cfg_step  = '0;
      cfg_dwell = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rate", 32'(toggle_rate), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_strobe", 32'(step_strobe), 32'd0);
      chk("rst_cycles", run_cycles, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);

      // Ramp up: 0,25,50,75,100 x4, done 21 cycles after start
      start_run(2'd0, 0, 100, 25, 4);
      exp_q = '{0, 25, 50, 75, 100};
      expect_seq(4, 1'b1);
`ifdef TOGGLE_SEQ_CYCLE_COUNT_EN
      chk("run_cycles", run_cycles, 32'd20);
`else
      chk("run_cycles", run_cycles, 32'd0);
`endif

      // Saturating step up and down
      start_run(2'd0, 0, 100, 30, 1);
      exp_q = '{0, 30, 60, 90, 100};
      expect_seq(1, 1'b1);
      start_run(2'd1, 0, 100, 30, 1);
      exp_q = '{100, 70, 40, 10, 0};
      expect_seq(1, 1'b1);

      // Triangle, then stop
      start_run(2'd2, 10, 30, 10, 2);
      exp_q.delete();
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(10);
         exp_q.push_back(20);
         exp_q.push_back(30);
         exp_q.push_back(20);
      end
      expect_seq(2, 1'b0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_rate", 32'(toggle_rate), 32'd0);
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_done", 32'(done), 32'd0);
      tick();
      chk("stop_done2", 32'(done), 32'd0);

      // Sanitising: clamp max, step 0 -> 1, dwell 0 -> 1
      start_run(2'd0, 50, 120, 0, 0);
      exp_q.delete();
      for (int i = 0; i <= 50; i++) exp_q.push_back(50 + i);
      expect_seq(1, 1'b1);
      start_run(2'd0, 90, 20, 5, 3);
      exp_q = '{90};
      expect_seq(3, 1'b1);

      // Config scrambled while busy has no effect
      start_run(2'd0, 0, 100, 25, 4);
      cfg_step  = 7'd1;
      cfg_max   = 7'd40;
      cfg_min   = 7'd5;
      cfg_mode  = 2'd3;
      cfg_dwell = 32'd1;
      exp_q = '{0, 25, 50, 75, 100};
      expect_seq(4, 1'b1);

      // start and stop together in IDLE
      cfg_mode = 2'd0;
      start    = 1'b1;
      stop     = 1'b1;
      tick();
      chk("ss_busy", 32'(busy), 32'd0);
      chk("ss_strobe", 32'(step_strobe), 32'd0);
      start = 1'b0;
      stop  = 1'b0;
      tick();
      chk("ss_busy2", 32'(busy), 32'd0);

      // Asynchronous reset during level 75
      start_run(2'd0, 0, 100, 25, 4);
      repeat (13) tick();
      chk("pre_rst_rate", 32'(toggle_rate), 32'd75);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_rate", 32'(toggle_rate), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_strobe", 32'(step_strobe), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_cycles", run_cycles, 32'd0);
      #1 rst_n = 1'b1;
      tick();
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_rate", 32'(toggle_rate), 32'd0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/toggle_rate_sequencer.md
Name: toggle_rate_sequencer

Overview:
Upstream control stage that generates the 7-bit toggle_rate (0..100 %) consumed by the logic, block-RAM and DSP power-load arrays. It replaces a static debug-probe value with a programmed profile: ramp up, ramp down, continuous triangle, or fixed. Each level is held for a programmed dwell time, so board power can be stepped and measured automatically. The configuration and the start/stop controls come from the debug VIO; toggle_rate drives the TOGGLE_RATE inputs of all load blocks.

Parameters:
TR_WIDTH, 7, width of rate fields and toggle_rate output
MAX_RATE, 100, hard ceiling applied to every rate value
DWELL_WIDTH, 32, width of dwell counter and cfg_dwell

Ports:
clk  input  1  single design clock; all logic is on posedge
rst_n  input  1  asynchronous active-low reset
start  input  1  level/pulse; sampled only in IDLE
stop  input  1  abort; sampled in every state
cfg_mode  input  2  0=ramp up, 1=ramp down, 2=triangle, 3=fixed
cfg_min  input  TR_WIDTH  lower rate bound
cfg_max  input  TR_WIDTH  upper rate bound
cfg_step  input  TR_WIDTH  increment per level
cfg_dwell  input  DWELL_WIDTH  cycles held at each level
toggle_rate  output  TR_WIDTH  current rate to the load blocks
busy  output  1  profile in progress
done  output  1  one-cycle pulse at normal completion
step_strobe  output  1  one-cycle pulse on the first cycle of each new level
run_cycles  output  32  active-cycle count (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): state IDLE; toggle_rate=0, busy=0, done=0, step_strobe=0, run_cycles=0.
- States: IDLE, RUN, DONE.
- IDLE: toggle_rate=0. If start=1 and stop=0, all cfg_* are latched into shadow registers and the state moves to RUN. On the next cycle toggle_rate shows the first level, busy=1 and step_strobe=1.
- Changes to cfg_* while busy are ignored.
- Latched values are sanitised as follows. min and max are each clamped to MAX_RATE. A step of 0 is treated as 1. A dwell of 0 is treated as 1. If min>max, max is forced to min.
- First level: ramp up, triangle and fixed start at min; ramp down starts at max.
- Each level is visible for exactly dwell cycles. There is no bubble between levels. step_strobe is high on the first cycle of every level, including the first.
- Ramp up: next level = min(cur+step, max). After the dwell at level max, go to DONE.
- Ramp down: next level = max(cur-step, min). This uses a signed or guarded subtract so there is no underflow wrap. After the dwell at level min, go to DONE.
- Triangle: ramps up to max, then reverses toward min, then reverses again, and repeats. Each endpoint is held for one dwell only, not two. The mode never reaches DONE. If min==max, the level stays constant and step_strobe fires once per dwell.
- Fixed: holds min indefinitely. step_strobe fires only on entry.
- DONE: lasts one cycle with done=1, busy=0, toggle_rate=0, then returns to IDLE.
- stop=1 in RUN: on the next cycle the state is IDLE with toggle_rate=0 and busy=0. done is not asserted.
- start and stop high together in IDLE: stop wins and nothing starts.
- start held high continuously: a new run begins on the cycle after DONE returns to IDLE.
- Reset asserted mid-run: outputs return to reset values immediately (asynchronous).
- Internal arithmetic is TR_WIDTH+1 bits wide so that cur+step cannot overflow before the clamp.

Optional Feature:
Macro TOGGLE_SEQ_CYCLE_COUNT_EN.
- Defined: run_cycles is a 32-bit counter. It clears on the cycle RUN is entered and increments every cycle busy=1. It holds its value after DONE or stop until the next start, and saturates at all-ones.
- Not defined: run_cycles is tied to 0 and no counter logic is generated.

Decomposition:
- Package toggle_seq_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - mode constants (MODE_UP=0, MODE_DOWN=1, MODE_TRI=2, MODE_FIXED=3)
  - MAX_RATE=100
  - a direction-flag typedef for triangle mode
- One sub-module, toggle_dwell_timer: a loadable DWELL_WIDTH down-counter. It takes load/value inputs and produces a one-cycle expire pulse on the last cycle of a dwell.

Test Plan:
- Ramp up: mode 0, min=0, max=100, step=25, dwell=4, start pulse. Required: toggle_rate 0,25,50,75,100 with 4 cycles each and step_strobe on each first cycle. done is high exactly 21 cycles after the start cycle, then toggle_rate=0.
- Saturating step: mode 0, min=0, max=100, step=30, dwell=1. Required: levels 0,30,60,90,100 then done. Ramp down with the same settings gives levels 100,70,40,10,0.
- Triangle: mode 2, min=10, max=30, step=10, dwell=2. Required: 10,10,20,20,30,30,20,20,10,10,20,... with no done after 40 cycles. Then stop=1, and on the next cycle toggle_rate=0 and busy=0 with no done.
- Sanitising: min=50, max=120, step=0, dwell=0, mode 0. Required: every level 50..100 in steps of 1, one cycle each, giving 51 levels, then done. A second run with min=90, max=20 holds 90 for one dwell, then done.
- Config change mid-run: change cfg_step while busy. Required: no effect on the sequence. Also check start and stop together in IDLE: busy stays 0.
- Reset mid-run: drop rst_n during level 75 of the ramp-up run. Required: all outputs return to 0 immediately (asynchronous). With TOGGLE_SEQ_CYCLE_COUNT_EN defined, run_cycles=20 after the 21-cycle ramp-up run completes.
